// File: rtl/pinmux_pkg.sv
// Shared types and constants for the pad multiplexer.
package pinmux_pkg;

   // Per-pin function-switch state.
   typedef enum logic {
      ACTIVE = 1'b0,
      SWITCH = 1'b1
   } pin_state_e;

   // Well-known function indices on every pad.
   localparam int FN_GPIO = 0;
   localparam int FN_SPI  = 1;
   localparam int FN_I2C  = 2;
   localparam int FN_PWM  = 3;

   // Width of one function-select field; at least one bit.
   function automatic int fsel_w(input int num_funcs);
      return (num_funcs > 1) ? $clog2(num_funcs) : 1;
   endfunction

endpackage

// File: rtl/pinmux_pin.sv
// One pad: break-before-make FSM, output register, input sync/filter and input fan-out.
module pinmux_pin
   import pinmux_pkg::*;
#(
   parameter int                   NUM_FUNCS   = 4,
   parameter int                   SYNC_STAGES = 2,
   parameter int                   BBM_CYCLES  = 2,
   parameter int                   FILT_CYCLES = 4,
   parameter logic [NUM_FUNCS-1:0] ALT_IDLE    = '1,
   localparam int                  FSEL_W      = fsel_w(NUM_FUNCS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [FSEL_W-1:0]    func_sel_i,
   input  logic                 lock_i,
   input  logic                 filt_en_i,
   output logic [FSEL_W-1:0]    func_cur_o,
   output logic                 switching_o,
   output logic                 illegal_o,
   input  logic [NUM_FUNCS-1:0] fn_out_i,
   input  logic [NUM_FUNCS-1:0] fn_oen_i,
   output logic [NUM_FUNCS-1:0] fn_in_o,
   input  logic                 pad_in_i,
   output logic                 pad_out_o,
   output logic                 pad_oen_o
);

   localparam int CNT_W  = $clog2(BBM_CYCLES + 1);
   localparam int FCNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  BBM_LD   = CNT_W'(BBM_CYCLES);
   localparam logic [FCNT_W-1:0] FILT_TOP = FCNT_W'(FILT_CYCLES - 1);

   pin_state_e        state_q, state_d;
   logic [FSEL_W-1:0] cur_q, cur_d;
   logic [FSEL_W-1:0] target_q, target_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FSEL_W-1:0] sel_legal;
   logic              sel_ok;

   logic              pad_o_q, pad_o_d;
   logic              pad_oen_q, pad_oen_d;
   logic              force_z;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   filt_q, filt_d;
   logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
   logic                   filt_en_q;
   logic                   in_val;

   // Out-of-range selections fall back to GPIO.
   assign sel_ok    = (int'(func_sel_i) < NUM_FUNCS);
   assign sel_legal = sel_ok ? func_sel_i : '0;
   assign illegal_o = ~sel_ok & ~lock_i;

   // Next-state logic: start, restart or finish a break-before-make window.
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      case (state_q)
         ACTIVE: begin
            if (!lock_i && sel_legal != cur_q) begin
               state_d  = SWITCH;
               target_d = sel_legal;
               cnt_d    = BBM_LD;
            end
         end
         SWITCH: begin
            if (!lock_i && sel_legal != target_q) begin
               target_d = sel_legal;
               cnt_d    = BBM_LD;
            end else if (cnt_q == CNT_W'(1)) begin
               cur_d   = target_q;
               cnt_d   = '0;
               state_d = ACTIVE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ACTIVE;
      endcase
   end

   // FSM state, applied function, latched target and window counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ACTIVE;
         cur_q    <= '0;
         target_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

   // Pad is held high-Z on entry to, during, and on the exit cycle of a window,
   // so the old function never drives after the selection has moved.
   always_comb begin
      force_z   = (state_q == SWITCH) || (state_d == SWITCH);
      pad_o_d   = force_z ? 1'b0 : fn_out_i[cur_q];
      pad_oen_d = force_z ? 1'b1 : fn_oen_i[cur_q];
   end

   // Registered pad drive.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pad_o_q   <= 1'b0;
         pad_oen_q <= 1'b1;
      end else begin
         pad_o_q   <= pad_o_d;
         pad_oen_q <= pad_oen_d;
      end
   end

   // Input synchroniser chain and registered filter enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '1;
         filt_en_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], pad_in_i};
         filt_en_q <= filt_en_i;
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Glitch filter: follow the input only after FILT_CYCLES differing samples in a row.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      if (synced == filt_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == FILT_TOP) begin
         filt_d = synced;
         fcnt_d = '0;
      end else begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   // Filter state runs continuously so toggling the enable never loses history.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= 1'b1;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign in_val = filt_en_q ? filt_q : synced;

   // Only the applied function sees the pad; everything idles during a window.
   always_comb begin
      for (int f = 0; f < NUM_FUNCS; f++) begin
         fn_in_o[f] = (state_q == ACTIVE && cur_q == FSEL_W'(f)) ? in_val : ALT_IDLE[f];
      end
   end

   assign func_cur_o  = cur_q;
   assign switching_o = (state_q == SWITCH);
   assign pad_out_o   = pad_o_q;
   assign pad_oen_o   = pad_oen_q;

endmodule

// File: rtl/pinmux_ctrl.sv
// Run-time pad multiplexer: per-pin function select with break-before-make,
// configuration lock and sticky illegal-select flag.
module pinmux_ctrl
   import pinmux_pkg::*;
#(
   parameter int                             NUM_PINS    = 32,
   parameter int                             NUM_FUNCS   = 4,
   parameter int                             SYNC_STAGES = 2,
   parameter int                             BBM_CYCLES  = 2,
   parameter int                             FILT_CYCLES = 4,
   parameter logic [NUM_PINS*NUM_FUNCS-1:0]  ALT_IDLE    = '1,
   localparam int                            FSEL_W      = fsel_w(NUM_FUNCS)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_PINS*FSEL_W-1:0]    func_sel,
   input  logic [NUM_PINS-1:0]           filt_en,
   input  logic                          cfg_lock,
   input  logic                          err_clr,
   output logic [NUM_PINS*FSEL_W-1:0]    func_cur,
   output logic [NUM_PINS-1:0]           switching,
   output logic                          cfg_err,
   input  logic [NUM_PINS*NUM_FUNCS-1:0] fn_o,
   input  logic [NUM_PINS*NUM_FUNCS-1:0] fn_oen,
   output logic [NUM_PINS*NUM_FUNCS-1:0] fn_i,
   input  logic [NUM_PINS-1:0]           pad_i,
   output logic [NUM_PINS-1:0]           pad_o,
   output logic [NUM_PINS-1:0]           pad_oen
);

   logic                lock_q, lock_d;
   logic                err_q, err_d;
   logic [NUM_PINS-1:0] pin_illegal;

   for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
      pinmux_pin #(
         .NUM_FUNCS  (NUM_FUNCS),
         .SYNC_STAGES(SYNC_STAGES),
         .BBM_CYCLES (BBM_CYCLES),
         .FILT_CYCLES(FILT_CYCLES),
         .ALT_IDLE   (ALT_IDLE[p*NUM_FUNCS +: NUM_FUNCS])
      ) u_pin (
         .clk        (clk),
         .reset_n    (reset_n),
         .func_sel_i (func_sel[p*FSEL_W +: FSEL_W]),
         .lock_i     (lock_q),
         .filt_en_i  (filt_en[p]),
         .func_cur_o (func_cur[p*FSEL_W +: FSEL_W]),
         .switching_o(switching[p]),
         .illegal_o  (pin_illegal[p]),
         .fn_out_i   (fn_o[p*NUM_FUNCS +: NUM_FUNCS]),
         .fn_oen_i   (fn_oen[p*NUM_FUNCS +: NUM_FUNCS]),
         .fn_in_o    (fn_i[p*NUM_FUNCS +: NUM_FUNCS]),
         .pad_in_i   (pad_i[p]),
         .pad_out_o  (pad_o[p]),
         .pad_oen_o  (pad_oen[p])
      );
   end

   // Lock is sticky; an illegal select beats a simultaneous clear.
   always_comb begin
      lock_d = lock_q | cfg_lock;
      err_d  = err_q;
      if (|pin_illegal) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   // Lock and error flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         lock_q <= lock_d;
         err_q  <= err_d;
      end
   end

   assign cfg_err = err_q;

endmodule

// File: tb/tb_pinmux_ctrl.sv
// Directed self-checking bench for pinmux_ctrl (default build plus a 3-function build).
module tb_pinmux_ctrl;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // default build: 32 pins, 4 functions
   logic [63:0]  func_sel = '0;
   logic [31:0]  filt_en = '0;
   logic         cfg_lock = 1'b0, err_clr = 1'b0;
   logic [63:0]  func_cur;
   logic [31:0]  switching;
   logic         cfg_err;
   logic [127:0] fn_o = '0, fn_oen = '0, fn_i;
   logic [31:0]  pad_i = '1, pad_o, pad_oen;

   // 3-function build: 2 pins
   logic [3:0]   func_sel3 = '0;
   logic [1:0]   filt_en3 = '0;
   logic         lock3 = 1'b0, clr3 = 1'b0;
   logic [3:0]   func_cur3;
   logic [1:0]   sw3;
   logic         err3;
   logic [5:0]   fn_o3 = '0, fn_oen3 = '0, fn_i3;
   logic [1:0]   pad_i3 = '1, pad_o3, pad_oen3;

   always #5 clk = ~clk;

   pinmux_ctrl u_dut (
      .clk(clk), .reset_n(reset_n), .func_sel(func_sel), .filt_en(filt_en),
      .cfg_lock(cfg_lock), .err_clr(err_clr), .func_cur(func_cur),
      .switching(switching), .cfg_err(cfg_err), .fn_o(fn_o), .fn_oen(fn_oen),
      .fn_i(fn_i), .pad_i(pad_i), .pad_o(pad_o), .pad_oen(pad_oen)
   );

   pinmux_ctrl #(.NUM_PINS(2), .NUM_FUNCS(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .func_sel(func_sel3), .filt_en(filt_en3),
      .cfg_lock(lock3), .err_clr(clr3), .func_cur(func_cur3),
      .switching(sw3), .cfg_err(err3), .fn_o(fn_o3), .fn_oen(fn_oen3),
      .fn_i(fn_i3), .pad_i(pad_i3), .pad_o(pad_o3), .pad_oen(pad_oen3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] pat;
      reset_n = 1'b0;
      fn_o = '1;
      fn_oen = '0;
      step(); step();
      checks++; if (pad_oen !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_pad_oen got=%h exp=ffffffff", pad_oen); end
      checks++; if (pad_o !== 32'h0) begin failures++; $display("FAIL rst_pad_o got=%h exp=0", pad_o); end
      checks++; if (fn_i !== '1) begin failures++; $display("FAIL rst_fn_i got=%h exp=all1", fn_i); end
      checks++; if (func_cur !== 64'h0 || switching !== 32'h0 || cfg_err !== 1'b0) begin
         failures++; $display("FAIL rst_state cur=%h sw=%h err=%b exp 0/0/0", func_cur, switching, cfg_err); end
      pat = 32'hAAAA_AAAA;
      for (int p = 0; p < 32; p++) fn_o[p*4] = pat[p];
      reset_n = 1'b1;
      step();
      checks++; if (pad_o !== pat || pad_oen !== 32'h0) begin
         failures++; $display("FAIL out_first pad_o=%h oen=%h exp %h/0", pad_o, pad_oen, pat); end
      for (int p = 0; p < 32; p++) fn_o[p*4] = ~pat[p];
      #1;
      checks++; if (pad_o !== pat) begin failures++; $display("FAIL out_hold got=%h exp=%h", pad_o, pat); end
      step();
      checks++; if (pad_o !== ~pat) begin failures++; $display("FAIL out_follow got=%h exp=%h", pad_o, ~pat); end
   endtask

   task automatic test_reset_mid_switch();
      func_sel[5:4] = 2'd1;
      step();
      checks++; if (switching[2] !== 1'b1) begin failures++; $display("FAIL mid_sw_start got=%b exp=1", switching[2]); end
      reset_n = 1'b0;
      #1;
      checks++; if (switching !== 32'h0 || func_cur !== 64'h0 || pad_oen !== 32'hFFFF_FFFF) begin
         failures++; $display("FAIL mid_sw_abort sw=%h cur=%h oen=%h exp 0/0/all1", switching, func_cur, pad_oen); end
      func_sel[5:4] = 2'd0;
      step();
      reset_n = 1'b1;
      step(); step();
   endtask

   task automatic test_switch();
      pad_i[5] = 1'b0;
      fn_o[20] = 1'b0; fn_oen[20] = 1'b0;
      fn_o[22] = 1'b1; fn_oen[22] = 1'b0;
      step(); step(); step();
      checks++; if (pad_o[5] !== 1'b0 || pad_oen[5] !== 1'b0 || fn_i[23:20] !== 4'b1110) begin
         failures++; $display("FAIL sw_pre pad_o=%b oen=%b fn_i=%b exp 0/0/1110", pad_o[5], pad_oen[5], fn_i[23:20]); end
      func_sel[11:10] = 2'd2;
      #1;
      checks++; if (switching[5] !== 1'b0) begin failures++; $display("FAIL sw_notyet got=%b exp=0", switching[5]); end
      for (int c = 1; c <= 2; c++) begin
         step();
         checks++; if (switching[5] !== 1'b1 || pad_oen[5] !== 1'b1 || pad_o[5] !== 1'b0 || func_cur[11:10] !== 2'd0) begin
            failures++; $display("FAIL sw_win c=%0d sw=%b oen=%b po=%b cur=%0d exp 1/1/0/0", c, switching[5], pad_oen[5], pad_o[5], func_cur[11:10]); end
         checks++; if (fn_i[23:20] !== 4'hF) begin failures++; $display("FAIL sw_idle c=%0d got=%b exp=1111", c, fn_i[23:20]); end
      end
      step();
      checks++; if (switching[5] !== 1'b0 || func_cur[11:10] !== 2'd2 || pad_oen[5] !== 1'b1) begin
         failures++; $display("FAIL sw_done sw=%b cur=%0d oen=%b exp 0/2/1", switching[5], func_cur[11:10], pad_oen[5]); end
      checks++; if (fn_i[23:20] !== 4'b1011) begin failures++; $display("FAIL sw_fn_i got=%b exp=1011", fn_i[23:20]); end
      step();
      checks++; if (pad_o[5] !== 1'b1 || pad_oen[5] !== 1'b0) begin
         failures++; $display("FAIL sw_out pad_o=%b oen=%b exp 1/0", pad_o[5], pad_oen[5]); end
      checks++; if (switching[4] !== 1'b0 || switching[6] !== 1'b0) begin
         failures++; $display("FAIL sw_neigh got=%b%b exp=00", switching[6], switching[4]); end
   endtask

   task automatic test_restart();
      func_sel[1:0] = 2'd1;
      step();
      checks++; if (switching[0] !== 1'b1) begin failures++; $display("FAIL rs_start got=%b exp=1", switching[0]); end
      func_sel[1:0] = 2'd3;
      step();
      checks++; if (switching[0] !== 1'b1 || func_cur[1:0] !== 2'd0) begin
         failures++; $display("FAIL rs_c2 sw=%b cur=%0d exp 1/0", switching[0], func_cur[1:0]); end
      step();
      checks++; if (switching[0] !== 1'b1 || func_cur[1:0] !== 2'd0) begin
         failures++; $display("FAIL rs_c3 sw=%b cur=%0d exp 1/0", switching[0], func_cur[1:0]); end
      step();
      checks++; if (switching[0] !== 1'b0 || func_cur[1:0] !== 2'd3) begin
         failures++; $display("FAIL rs_done sw=%b cur=%0d exp 0/3", switching[0], func_cur[1:0]); end
   endtask

   task automatic test_filter();
      logic exp;
      filt_en[7] = 1'b1;
      step(); step(); step();
      checks++; if (fn_i[28] !== 1'b1) begin failures++; $display("FAIL flt_pre got=%b exp=1", fn_i[28]); end
      // 3-cycle glitch: must be swallowed
      pad_i[7] = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 3) pad_i[7] = 1'b1;
         checks++; if (fn_i[28] !== 1'b1) begin failures++; $display("FAIL flt_glitch k=%0d got=%b exp=1", k, fn_i[28]); end
      end
      // 4-cycle pulse: passes with SYNC_STAGES+FILT_CYCLES latency
      pad_i[7] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 4) pad_i[7] = 1'b1;
         exp = (k >= 6 && k <= 9) ? 1'b0 : 1'b1;
         checks++; if (fn_i[28] !== exp) begin failures++; $display("FAIL flt_pulse k=%0d got=%b exp=%b", k, fn_i[28], exp); end
      end
      // unfiltered pin 8: one-cycle pulse after SYNC_STAGES cycles
      pad_i[8] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k == 1) pad_i[8] = 1'b1;
         exp = (k == 2) ? 1'b0 : 1'b1;
         checks++; if (fn_i[32] !== exp) begin failures++; $display("FAIL nofilt k=%0d got=%b exp=%b", k, fn_i[32], exp); end
      end
   endtask

   task automatic test_illegal();
      func_sel3[1:0] = 2'd1;
      step(); step(); step(); step();
      checks++; if (func_cur3[1:0] !== 2'd1 || err3 !== 1'b0) begin
         failures++; $display("FAIL ill_pre cur=%0d err=%b exp 1/0", func_cur3[1:0], err3); end
      func_sel3[1:0] = 2'd3;
      step();
      checks++; if (err3 !== 1'b1 || sw3[0] !== 1'b1) begin
         failures++; $display("FAIL ill_set err=%b sw=%b exp 1/1", err3, sw3[0]); end
      step(); step();
      checks++; if (func_cur3[1:0] !== 2'd0 || sw3[0] !== 1'b0) begin
         failures++; $display("FAIL ill_to0 cur=%0d sw=%b exp 0/0", func_cur3[1:0], sw3[0]); end
      clr3 = 1'b1;
      step();
      checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL ill_setwins got=%b exp=1", err3); end
      func_sel3[1:0] = 2'd0;
      step();
      checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL ill_clr got=%b exp=0", err3); end
      clr3 = 1'b0;
   endtask

   task automatic test_lock();
      func_sel[3:2] = 2'd1;
      step(); step(); step(); step();
      checks++; if (func_cur[3:2] !== 2'd1) begin failures++; $display("FAIL lk_pre got=%0d exp=1", func_cur[3:2]); end
      cfg_lock = 1'b1;
      step();
      cfg_lock = 1'b0;
      func_sel[3:2] = 2'd0;
      for (int k = 1; k <= 5; k++) begin
         step();
         checks++; if (func_cur[3:2] !== 2'd1 || switching[1] !== 1'b0) begin
            failures++; $display("FAIL lk_hold k=%0d cur=%0d sw=%b exp 1/0", k, func_cur[3:2], switching[1]); end
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      checks++; if (func_cur[3:2] !== 2'd0) begin failures++; $display("FAIL lk_rst got=%0d exp=0", func_cur[3:2]); end
      func_sel[3:2] = 2'd2;
      step();
      checks++; if (switching[1] !== 1'b1) begin failures++; $display("FAIL lk_cleared got=%b exp=1", switching[1]); end
      step(); step();
      checks++; if (func_cur[3:2] !== 2'd2) begin failures++; $display("FAIL lk_after got=%0d exp=2", func_cur[3:2]); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_switch();
      test_switch();
      test_restart();
      test_filter();
      test_illegal();
      test_lock();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
